// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: parity modes, frame
// states, data-length limits and the parity/length helper functions.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    MARK = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int MIN_DATA_W = 5;
  localparam int MAX_DATA_W = 9;

  // Only the low len bits take part; bits at or above len are ignored.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                       input logic [3:0]            len,
                                       input parity_e               mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < int'(len)) x = x ^ data[i];
    end
    case (mode)
      EVEN:    return x;
      ODD:     return ~x;
      MARK:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] cfg_len,
                                           input int         max_len);
    if (int'(cfg_len) > max_len) return 4'(max_len);
    if (int'(cfg_len) < MIN_DATA_W) return 4'(MIN_DATA_W);
    return cfg_len;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// UART transmitter with runtime data length, parity and stop-bit selection,
// plus a one-entry holding register so frames can go out back-to-back.
//
// state  | meaning
// IDLE   | line idle high, waiting for a tick with the holding register full
// START  | start bit (0) on the line
// DATA   | data bits on the line, LSB first
// PARITY | parity bit on the line
// STOP   | one or two stop bits (1) on the line
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [3:0]        cfg_data_len,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              tx_pin,
  output logic              tx_busy,
  output logic              tx_done
);

  tx_state_e         state_q;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] shift_q;
  logic [3:0]        bit_idx_q;
  logic [3:0]        len_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              stop_cnt_q;
  logic              tx_pin_q;
  logic              busy_q;
  logic              done_q;

  // Frame settings as they would be frozen if a start bit went out this cycle.
  logic [MAX_DATA_W-1:0] hold_ext;
  logic [3:0]            len_d;
  parity_e               par_mode_d;
  logic                  par_bit_d;

  assign hold_ext   = MAX_DATA_W'(hold_q);
  assign len_d      = clamp_len(cfg_data_len, DATA_W);
  assign par_mode_d = parity_e'(cfg_parity);
  assign par_bit_d  = calc_parity(hold_ext, len_d, par_mode_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      len_q       <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_cnt_q  <= 1'b0;
      tx_pin_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Accept and drain are mutually exclusive: both depend on hold_full_q.
      if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      if (baud_tick) begin
        case (state_q)
          IDLE: begin
            tx_pin_q <= 1'b1;
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              len_q       <= len_d;
              par_en_q    <= (par_mode_d != NONE);
              par_bit_q   <= par_bit_d;
              stop2_q     <= cfg_stop2;
              bit_idx_q   <= '0;
              stop_cnt_q  <= 1'b0;
              tx_pin_q    <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= START;
            end
          end
          START: begin
            tx_pin_q  <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= 4'd1;
            state_q   <= DATA;
          end
          DATA: begin
            if (bit_idx_q < len_q) begin
              tx_pin_q  <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 4'd1;
            end else if (par_en_q) begin
              tx_pin_q <= par_bit_q;
              state_q  <= PARITY;
            end else begin
              tx_pin_q   <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= STOP;
            end
          end
          PARITY: begin
            tx_pin_q   <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= STOP;
          end
          STOP: begin
            if (stop2_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
              tx_pin_q   <= 1'b1;
            end else begin
              done_q <= 1'b1;
              // A waiting byte goes straight into its start bit: no idle gap.
              if (hold_full_q) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                len_q       <= len_d;
                par_en_q    <= (par_mode_d != NONE);
                par_bit_q   <= par_bit_d;
                stop2_q     <= cfg_stop2;
                bit_idx_q   <= '0;
                stop_cnt_q  <= 1'b0;
                tx_pin_q    <= 1'b0;
                state_q     <= START;
              end else begin
                tx_pin_q <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= IDLE;
              end
            end
          end
          default: begin
            tx_pin_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready = !hold_full_q;
  assign tx_pin   = tx_pin_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule
